// File: rtl/pwm_generator.sv
// pwm_generator: fixed-period PWM source whose duty is latched only at period boundaries
module pwm_generator #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] counter,
  output logic             pwmout,
  output logic             period_start
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);
  logic [WIDTH-1:0] counter_q, counter_d, duty_q, duty_d;
  logic             pwm_q, pwm_d, ps_q, ps_d, wrap;
  // next state: wrap the counter, reload the duty shadow on wrap, compare against the values being loaded
  always_comb begin
    wrap      = counter_q == LAST;
    counter_d = wrap ? '0 : counter_q + 1'b1;
    duty_d    = wrap ? duty : duty_q;
    pwm_d     = counter_d < duty_d;
    ps_d      = wrap;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      counter_q <= counter_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end
  assign counter      = counter_q;
  assign pwmout       = pwm_q;
  assign period_start = ps_q;
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: scoreboard bench for the default PWM and a full-range PERIOD=256 variant
module tb_pwm_generator;
  logic       clk, rst_n;
  logic [7:0] duty, duty2, counter, counter2;
  logic       pwmout, pwmout2, period_start, period_start2;
  int n_assert = 0, n_fail = 0;
  typedef struct {
    int cnt; int pwm; int ps; int pd;
    int cnt2; int pwm2; int ps2; int pd2;
  } exp_t;
  exp_t q[$];
  int m_cnt, m_duty, m_ps, m_pwm, hi;
  int m_cnt2, m_duty2, m_ps2, m_pwm2, hi2;

  pwm_generator #(.WIDTH(8), .PERIOD(100)) dut (
    .clk(clk), .rst_n(rst_n), .duty(duty),
    .counter(counter), .pwmout(pwmout), .period_start(period_start)
  );
  pwm_generator #(.WIDTH(8), .PERIOD(256)) dut2 (
    .clk(clk), .rst_n(rst_n), .duty(duty2),
    .counter(counter2), .pwmout(pwmout2), .period_start(period_start2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_ps = 0; m_pwm = 0; hi = 0;
    m_cnt2 = 0; m_duty2 = 0; m_ps2 = 0; m_pwm2 = 0; hi2 = 0;
  endtask

  task automatic step();
    exp_t e;
    int pd, pd2;
    @(posedge clk);
    pd = m_duty;
    pd2 = m_duty2;
    if (!rst_n) model_reset();
    else begin
      m_ps = (m_cnt == 99);
      m_cnt = m_ps ? 0 : m_cnt + 1;
      if (m_ps) m_duty = int'(duty);
      m_pwm = (m_cnt < m_duty) ? 1 : 0;
      m_ps2 = (m_cnt2 == 255);
      m_cnt2 = m_ps2 ? 0 : m_cnt2 + 1;
      if (m_ps2) m_duty2 = int'(duty2);
      m_pwm2 = (m_cnt2 < m_duty2) ? 1 : 0;
    end
    e = '{m_cnt, m_pwm, m_ps, pd, m_cnt2, m_pwm2, m_ps2, pd2};
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk("counter", 32'(counter), e.cnt);
    chk("pwmout", 32'(pwmout), e.pwm);
    chk("period_start", 32'(period_start), e.ps);
    chk("counter_p256", 32'(counter2), e.cnt2);
    chk("pwmout_p256", 32'(pwmout2), e.pwm2);
    chk("period_start_p256", 32'(period_start2), e.ps2);
    if (!rst_n) begin
      hi = 0;
      hi2 = 0;
    end else begin
      if (e.ps) begin
        chk("high_time", hi, (e.pd < 100) ? e.pd : 100);
        hi = int'(pwmout);
      end else hi += int'(pwmout);
      if (e.ps2) begin
        chk("high_time_p256", hi2, (e.pd2 < 256) ? e.pd2 : 256);
        hi2 = int'(pwmout2);
      end else hi2 += int'(pwmout2);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int sweep[6] = '{0, 10, 40, 50, 80, 90};
    rst_n = 1'b0;
    duty = 8'd50;
    duty2 = 8'd128;
    model_reset();
    run(5);
    rst_n = 1'b1;
    run(3);
    for (int i = 0; i < 6; i++) begin
      duty = 8'(sweep[i]);
      run(200);
    end
    duty = 8'd40;
    run(200);
    for (int i = 0; i < 200 && m_cnt != 30; i++) step();
    chk("mid_at_30", 32'(counter), 30);
    duty = 8'd80;
    run(220);
    duty = 8'd100;
    run(400);
    duty = 8'd255;
    run(400);
    duty = 8'd0;
    run(300);
    duty = 8'd99;
    run(300);
    duty = 8'd60;
    run(150);
    #3 rst_n = 1'b0;
    #1;
    chk("async_counter", 32'(counter), 0);
    chk("async_pwmout", 32'(pwmout), 0);
    chk("async_period_start", 32'(period_start), 0);
    chk("async_counter_p256", 32'(counter2), 0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(250);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
